seg_scan: RTL

- Consumer end of the watch display bus.
- Takes the six-digit segment bus (48 bits), the mode-digit segment byte and the alarm flag from the watch top level.
- Time-multiplexes them onto one physical 7-digit common-anode LED display: one shared segment bus plus per-digit anode enables.
- Adds frame-latched buffering (no tearing), inter-digit ghost blanking, 8-level brightness and alarm flashing.

---
 rtl/seg_scan_pkg.sv | 25 ++
 rtl/seg_scan_timer.sv | 36 +++
 rtl/seg_scan.sv | 80 ++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and polarity helpers for the multiplexed LED scanner.
package seg_scan_pkg;
   localparam int N_DIGITS = 7;

   typedef logic [2:0] slot_t;

   localparam slot_t LAST_SLOT = slot_t'(N_DIGITS - 1);

   // Convert "bit set = lit/selected" into the physical drive level.
   function automatic logic [7:0] seg_pol(input logic [7:0] lit, input bit active_low);
      return active_low ? ~lit : lit;
   endfunction

   function automatic logic [N_DIGITS-1:0] an_pol(input logic [N_DIGITS-1:0] sel, input bit active_low);
      return active_low ? ~sel : sel;
   endfunction

   function automatic logic [7:0] seg_off(input bit active_low);
      return seg_pol(8'h00, active_low);
   endfunction

   function automatic logic [N_DIGITS-1:0] an_off(input bit active_low);
      return an_pol('0, active_low);
   endfunction
endpackage

// File: rtl/seg_scan_timer.sv
// Dwell counter, digit slot sequencer and frame-start strobe generation.
module scan_timer
   import seg_scan_pkg::*;
#(
   parameter int DIG_LOG2 = 10
) (
   input  logic                clk,
   input  logic                rst,
   output logic [DIG_LOG2-1:0] cnt,
   output slot_t               slot,
   output logic                load,
   output logic                frame_o
);
   logic first_q;

   // The cycle right after reset release is held at cnt=0 so the reloaded
   // first frame has the same alignment as every later frame.
   assign load = first_q | ((&cnt) && (slot == LAST_SLOT));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         slot    <= '0;
         first_q <= 1'b1;
         frame_o <= 1'b0;
      end else begin
         first_q <= 1'b0;
         frame_o <= load;
         if (!first_q) begin
            cnt <= cnt + 1'b1;
            if (&cnt)
               slot <= (slot == LAST_SLOT) ? slot_t'(0) : slot + slot_t'(1);
         end
      end
   end
endmodule

// File: rtl/seg_scan.sv
// Seven-digit LED scanner: frame-latched buffer, ghost blanking, PWM brightness
// and alarm flashing on top of the shared scan timer.
module seg_scan
   import seg_scan_pkg::*;
#(
   parameter int DIG_LOG2     = 10,
   parameter int BLANK_CYC    = 4,
   parameter int BLINK_FRAMES = 64,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [47:0]         disp_i,
   input  logic [7:0]          mode_i,
   input  logic                alm_i,
   input  logic [2:0]          bright_i,
   output logic [7:0]          seg_o,
   output logic [N_DIGITS-1:0] an_o,
   output logic                frame_o
);
   localparam bit AL = (ACTIVE_LOW != 0);
   localparam logic [7:0]          SEG_OFF = seg_off(AL);
   localparam logic [N_DIGITS-1:0] AN_OFF  = an_off(AL);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DIG_LOG2-1:0]          cnt;
   slot_t                        slot;
   logic                         load;
   logic [N_DIGITS-1:0][7:0]     fbuf;
   logic [BW-1:0]                bcnt;
   logic                         phase;
   logic                         en;
   logic [N_DIGITS-1:0]          sel;

   scan_timer #(.DIG_LOG2(DIG_LOG2)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt),
      .slot    (slot),
      .load    (load),
      .frame_o (frame_o)
   );

   always_ff @(posedge clk) begin
      if (rst)
         fbuf <= '0;
      else if (load)
         fbuf <= {mode_i, disp_i};
   end

   // Flash phase runs regardless of alm_i so re-arming needs no alignment.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (frame_o) begin
         if (bcnt == BW'(BLINK_FRAMES - 1)) begin
            bcnt  <= '0;
            phase <= ~phase;
         end else begin
            bcnt <= bcnt + 1'b1;
         end
      end
   end

   assign en  = (cnt >= DIG_LOG2'(BLANK_CYC)) &&
                (cnt[DIG_LOG2-1 -: 3] <= bright_i) &&
                !(alm_i && phase);
   assign sel = N_DIGITS'(1) << slot;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         seg_o <= SEG_OFF;
         an_o  <= AN_OFF;
      end else begin
         seg_o <= seg_pol(fbuf[slot], AL);
         an_o  <= an_pol(sel, AL);
      end
   end
endmodule
